// File: rtl/mips_mem_pkg.sv
// Shared constants and elaboration helpers for the MIPS instruction memory.
package mips_mem_pkg;

  // sll $0,$0,0 -- the canonical MIPS no-op
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  // Per-response status carried alongside the fetched word
  typedef struct packed {
    logic valid;
    logic addr_fault;
    logic misalign;
  } fetch_flags_t;

  // Ceiling log2, usable in parameter expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Number of byte-offset bits inside one instruction word
  function automatic int unsigned off_w(input int unsigned data_w);
    return clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/instr_mem_sync_if.sv
// Fetch and load bus of the instruction memory.
interface instr_mem_sync_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              fetch_en;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              addr_fault;
  logic              misalign;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_err;

  modport master (
    output fetch_en, stall, flush, pc, load_we, load_addr, load_data,
    input  instr, instr_valid, addr_fault, misalign, load_err
  );

  modport slave (
    input  fetch_en, stall, flush, pc, load_we, load_addr, load_data,
    output instr, instr_valid, addr_fault, misalign, load_err
  );
endinterface

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage with one read-first synchronous read port and one
// write port. Contents are not reset; programs are loaded through the write
// port.
module instr_mem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  // Read port; samples the pre-write word on a same-edge collision
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the pipelined MIPS fetch stage.
// Optional build macro INSTR_MEM_WRAP_EN: indices wrap modulo DEPTH, no
// out-of-range faults are reported (legacy behaviour).
module instr_mem_sync
  import mips_mem_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 64,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_mem_sync_if.slave  bus
);

  localparam int unsigned       OFF_W    = off_w(DATA_W);
  localparam int unsigned       IDX_W    = clog2(DEPTH);
  localparam int unsigned       SPAN_W   = OFF_W + IDX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'(1) << OFF_W) - 64'(1));

  logic              fetch_mis_c;
  logic              fetch_oor_c;
  logic              load_mis_c;
  logic              load_oor_c;
  logic [IDX_W-1:0]  fetch_idx_c;
  logic [IDX_W-1:0]  load_idx_c;
  logic              rd_en_c;
  logic              wr_ok_c;
  logic [DATA_W-1:0] rd_data;

  fetch_flags_t flags_q, flags_d;
  logic         mem_sel_q, mem_sel_d;
  logic         load_err_q;
  logic         rst_done_q;

  // Address decode: word index, byte-offset check, range check
  assign fetch_idx_c = IDX_W'(bus.pc >> OFF_W);
  assign load_idx_c  = IDX_W'(bus.load_addr >> OFF_W);
  assign fetch_mis_c = (bus.pc & OFF_MASK) != '0;
  assign load_mis_c  = (bus.load_addr & OFF_MASK) != '0;
`ifdef INSTR_MEM_WRAP_EN
  assign fetch_oor_c = 1'b0;
  assign load_oor_c  = 1'b0;
`else
  assign fetch_oor_c = (bus.pc >> SPAN_W) != '0;
  assign load_oor_c  = (bus.load_addr >> SPAN_W) != '0;
`endif

  // Writes are blocked in reset and on the edge that releases it
  assign wr_ok_c = bus.load_we & ~load_mis_c & ~load_oor_c;

  // Next response state from stall / fetch / flush
  always_comb begin
    flags_d   = flags_q;
    mem_sel_d = mem_sel_q;
    rd_en_c   = 1'b0;
    if (!bus.stall) begin
      if (bus.fetch_en) begin
        if (bus.flush) begin
          flags_d   = '0;
          mem_sel_d = 1'b0;
        end else begin
          flags_d.valid      = 1'b1;
          flags_d.addr_fault = fetch_oor_c;
          flags_d.misalign   = fetch_mis_c;
          mem_sel_d          = ~(fetch_oor_c | fetch_mis_c);
          rd_en_c            = ~(fetch_oor_c | fetch_mis_c);
        end
      end else begin
        flags_d = '0;
      end
    end
  end

  // Response and load-status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= '0;
      mem_sel_q  <= 1'b0;
      load_err_q <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      flags_q    <= flags_d;
      mem_sel_q  <= mem_sel_d;
      load_err_q <= bus.load_we & (load_mis_c | load_oor_c);
      rst_done_q <= 1'b1;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (rd_en_c),
    .rd_idx  (fetch_idx_c),
    .rd_data (rd_data),
    .wr_en   (wr_ok_c & rst_done_q),
    .wr_idx  (load_idx_c),
    .wr_data (bus.load_data)
  );

  // Word register holds its last read while the selector picks NOP on faults
  assign bus.instr       = mem_sel_q ? rd_data : NOP_WORD;
  assign bus.instr_valid = flags_q.valid;
  assign bus.addr_fault  = flags_q.addr_fault;
  assign bus.misalign    = flags_q.misalign;
  assign bus.load_err    = load_err_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Randomised scoreboard bench for instr_mem_sync against a word-array model.
module tb_instr_mem_sync;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned BYTES = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        af;
    logic        ma;
    logic        lerr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_mem_sync_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  exp_t mon_e;

  // Model state
  logic [31:0] mem_m [DEPTH];
  exp_t        st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Outputs seen one step after the edge the entry was pushed for
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("instr",       bus.instr,              mon_e.instr);
      chk("instr_valid", 32'(bus.instr_valid),   32'(mon_e.valid));
      chk("addr_fault",  32'(bus.addr_fault),    32'(mon_e.af));
      chk("misalign",    32'(bus.misalign),      32'(mon_e.ma));
      chk("load_err",    32'(bus.load_err),      32'(mon_e.lerr));
    end
  end

  // Reference: what one clock edge does, stated in word/byte arithmetic
  task automatic model_step(input bit fe, input bit stl, input bit fl, input logic [31:0] p,
                            input bit we, input logic [31:0] la, input logic [31:0] ld,
                            input bit drop_wr);
    logic [31:0] ridx, widx;
    bit rmis, roor, wmis, woor;
    ridx = p / BYTES;   rmis = (p % BYTES) != 0;
    widx = la / BYTES;  wmis = (la % BYTES) != 0;
`ifdef INSTR_MEM_WRAP_EN
    ridx = ridx % DEPTH; roor = 1'b0;
    widx = widx % DEPTH; woor = 1'b0;
`else
    roor = ridx >= DEPTH;
    woor = widx >= DEPTH;
`endif
    if (!stl) begin
      if (!fe) begin
        st.valid = 1'b0; st.af = 1'b0; st.ma = 1'b0;
      end else if (fl) begin
        st.instr = NOP; st.valid = 1'b0; st.af = 1'b0; st.ma = 1'b0;
      end else begin
        st.valid = 1'b1; st.af = roor; st.ma = rmis;
        st.instr = (roor || rmis) ? NOP : mem_m[ridx];
      end
    end
    st.lerr = we && (wmis || woor);
    if (we && !wmis && !woor && !drop_wr) mem_m[widx] = ld;
  endtask

  task automatic drive_cycle(input bit fe, input bit stl, input bit fl, input logic [31:0] p,
                             input bit we, input logic [31:0] la, input logic [31:0] ld,
                             input bit release_rst);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    bus.fetch_en  = fe;
    bus.stall     = stl;
    bus.flush     = fl;
    bus.pc        = p;
    bus.load_we   = we;
    bus.load_addr = la;
    bus.load_data = ld;
    model_step(fe, stl, fl, p, we, la, ld, release_rst);
    q.push_back(st);
  endtask

  task automatic fetch(input logic [31:0] p);
    drive_cycle(1'b1, 1'b0, 1'b0, p, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic idle();
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)      return 32'($urandom_range(0, DEPTH - 1)) * BYTES;
    else if (r < 8) return 32'($urandom_range(0, DEPTH * BYTES - 1)) | 32'd1;
    else if (r < 9) return 32'($urandom_range(DEPTH * BYTES, DEPTH * BYTES * 2));
    else            return 32'($urandom);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr"},    bus.instr,            NOP);
    chk({tag, "_valid"},    32'(bus.instr_valid), 32'd0);
    chk({tag, "_fault"},    32'(bus.addr_fault),  32'd0);
    chk({tag, "_misalign"}, 32'(bus.misalign),    32'd0);
    chk({tag, "_load_err"}, 32'(bus.load_err),    32'd0);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p, la;
      p  = rand_addr();
      la = rand_addr();
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, p, $urandom_range(0, 3) == 0,
                  la, 32'($urandom), 1'b0);
    end
  endtask

  initial begin
    bus.fetch_en = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.pc = '0;
    bus.load_we = 1'b0;  bus.load_addr = '0; bus.load_data = '0;
    st = '{instr: NOP, valid: 1'b0, af: 1'b0, ma: 1'b0, lerr: 1'b0};
    #3;
    check_reset_outputs("reset");

    // Release reset together with a write that must be dropped
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd2 * BYTES, 32'hDEAD_BEEF, 1'b1);

    // Program image load; word 2 carries the known instruction
    for (int i = 0; i < int'(DEPTH); i++)
      drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'(i) * BYTES,
                  (i == 2) ? 32'h0109_8020 : 32'($urandom), 1'b0);

    fetch(32'd8);
    fetch(32'd4);
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 1'b1, 1'b1, 32'd12, 1'b0, 32'd0, 32'd0, 1'b0);
    fetch(32'd12);
    idle();
    fetch(32'd256);
    fetch(32'd6);
    drive_cycle(1'b1, 1'b0, 1'b1, 32'd8, 1'b0, 32'd0, 32'd0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 32'd16, 1'b1, 32'd16, 32'hAC15_0008, 1'b0);
    fetch(32'd16);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd258, 32'h1234_5678, 1'b0);
    idle();
    fetch(32'd64 * BYTES - BYTES);

    random_phase(400);

    // Asynchronous reset mid-stream; memory must survive it
    @(posedge clk);
    #3;
    bus.fetch_en = 1'b1; bus.pc = 32'd16;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    st = '{instr: NOP, valid: 1'b0, af: 1'b0, ma: 1'b0, lerr: 1'b0};
    repeat (2) @(posedge clk);
    drive_cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd16, 32'h5555_AAAA, 1'b1);
    fetch(32'd16);
    fetch(32'd8);
    fetch(32'd0);

    random_phase(150);
    idle();

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
